// File: rtl/decoder_pkg.sv
// Shared constants and helpers for the PWM symbol decoder.
// DEF_DATA_W / DEF_SYM_W are the default widths used by the decoder
// modules; SYM_MAX is the largest positive symbol at the default width.
package decoder_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_SYM_W  = 8;
  localparam int SYM_MAX    = (1 << (DEF_SYM_W - 1)) - 1;

  // Clamp a signed integer into the range of a width-bit two's complement value.
  function automatic int sat_signed(input int value, input int width);
    int hi;
    int lo;
    hi = (1 << (width - 1)) - 1;
    lo = -(1 << (width - 1));
    if (value > hi)
      return hi;
    else if (value < lo)
      return lo;
    else
      return value;
  endfunction

endpackage

// File: rtl/pwm_level_detector.sv
// Hysteresis comparator for the PWM symbol decoder.
// The comparison is done two bits wider than the sample so that
// ref_in +/- HYST cannot wrap. level_next is the combinational decision
// for the current sample; level_q is that decision registered.
module pwm_level_detector
  import decoder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int HYST   = 0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic signed [DATA_W-1:0] ref_in,
  input  logic signed [DATA_W-1:0] data_in,
  output logic                     level_next,
  output logic                     level_q
);

  localparam int EXT_W = DATA_W + 2;

  logic signed [EXT_W-1:0] data_ext;
  logic signed [EXT_W-1:0] ref_ext;
  logic signed [EXT_W-1:0] hyst_ext;
  logic signed [EXT_W-1:0] upper;
  logic signed [EXT_W-1:0] lower;

  assign data_ext = {{2{data_in[DATA_W-1]}}, data_in};
  assign ref_ext  = {{2{ref_in[DATA_W-1]}}, ref_in};
  assign hyst_ext = EXT_W'(HYST);
  assign upper    = ref_ext + hyst_ext;
  assign lower    = ref_ext - hyst_ext;

  // Decide the new level; inside the hysteresis band the old level is kept.
  always_comb begin
    level_next = level_q;
    if (data_ext > upper)
      level_next = 1'b1;
    else if (data_ext <= lower)
      level_next = 1'b0;
  end

  // Register the level so the top can spot high-to-low transitions.
  always_ff @(posedge clock) begin
    if (!reset_n)
      level_q <= 1'b0;
    else
      level_q <= level_next;
  end

endmodule

// File: rtl/pwm_symbol_decoder.sv
// Pulse-width demodulator: counts enabled clocks while the sample is above
// threshold and emits the width as a signed symbol on each pulse end.
// Optional build macro DECODER_SIGNED_SYMBOL_EN: when defined, the emitted
// symbol is the width minus CENTER_VAL, saturated to the symbol range.
module pwm_symbol_decoder
  import decoder_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int SYM_W      = DEF_SYM_W,
  parameter int HYST       = 0,
  parameter int MIN_PULSE  = 2,
  parameter int CENTER_VAL = 64
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     enable_counter,
  input  logic signed [DATA_W-1:0] ref_in,
  input  logic signed [DATA_W-1:0] data_in,
  output logic signed [SYM_W-1:0]  decoded_symbol,
  output logic                     symbol_valid
);

`ifdef DECODER_SIGNED_SYMBOL_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  // Offset removed from the width before output; zero leaves the raw count.
  localparam int OFFSET = SIGNED_EN ? CENTER_VAL : 0;

  localparam logic [SYM_W-1:0] CNT_MAX = SYM_W'((1 << (SYM_W - 1)) - 1);
  localparam logic [SYM_W-1:0] MIN_CNT = SYM_W'(MIN_PULSE);

  logic             level_next;
  logic             level_q;
  logic             falling;
  logic [SYM_W-1:0] cnt;
  logic [SYM_W-1:0] sym_next;

  pwm_level_detector #(
    .DATA_W (DATA_W),
    .HYST   (HYST)
  ) u_level (
    .clock      (clock),
    .reset_n    (reset_n),
    .ref_in     (ref_in),
    .data_in    (data_in),
    .level_next (level_next),
    .level_q    (level_q)
  );

  assign falling  = level_q & ~level_next;
  assign sym_next = SYM_W'(sat_signed(int'(cnt) - OFFSET, SYM_W));

  // Width counter: counts enabled high samples, saturates, clears on pulse end.
  always_ff @(posedge clock) begin
    if (!reset_n)
      cnt <= '0;
    else if (falling)
      cnt <= '0;
    else if (level_next && enable_counter && (cnt != CNT_MAX))
      cnt <= cnt + 1'b1;
  end

  // Emit the symbol on a pulse end unless the pulse was too short.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      decoded_symbol <= '0;
      symbol_valid   <= 1'b0;
    end else begin
      symbol_valid <= 1'b0;
      if (falling && (cnt >= MIN_CNT)) begin
        decoded_symbol <= $signed(sym_next);
        symbol_valid   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_symbol_decoder.sv
// Directed self-checking bench for pwm_symbol_decoder (default parameters).
// Follows DECODER_SIGNED_SYMBOL_EN so expected symbols match either build.
module tb_pwm_symbol_decoder;

  logic               clock;
  logic               reset_n;
  logic               enable_counter;
  logic signed [15:0] ref_in;
  logic signed [15:0] data_in;
  logic signed [7:0]  decoded_symbol;
  logic               symbol_valid;

  int checks   = 0;
  int failures = 0;

  pwm_symbol_decoder dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable_counter (enable_counter),
    .ref_in         (ref_in),
    .data_in        (data_in),
    .decoded_symbol (decoded_symbol),
    .symbol_valid   (symbol_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected output for a decoded pulse of width n.
  function automatic int exp_sym(input int n);
    int v;
`ifdef DECODER_SIGNED_SYMBOL_EN
    v = n - 64;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
`else
    v = n;
`endif
    return v;
  endfunction

  // Present one sample and let one rising edge consume it; outputs sampled 1 ns later.
  task automatic apply_stimulus(input logic signed [15:0] d, input logic en);
    data_in        = d;
    enable_counter = en;
    @(posedge clock);
    #1;
  endtask

  // Compare one observed value against its expectation.
  task automatic check_output(input string tag, input logic signed [31:0] observed,
                              input logic signed [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive n high samples with enable held high, requiring no strobe meanwhile.
  task automatic run_pulse(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(16'sd100, 1'b1);
      check_output(tag, symbol_valid, 0);
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    enable_counter = 1'b1;
    ref_in         = 16'sd30;
    data_in        = 16'sd100;

    // Reset held for three clocks with a high sample present.
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check_output("reset_valid", symbol_valid, 0);
      check_output("reset_symbol", decoded_symbol, 0);
    end
    data_in = 16'sd0;
    reset_n = 1'b1;
    apply_stimulus(16'sd0, 1'b1);
    check_output("idle_valid", symbol_valid, 0);

    // Basic five-sample pulse.
    run_pulse(5, "basic_mid_valid");
    apply_stimulus(16'sd0, 1'b1);
    check_output("basic_valid", symbol_valid, 1);
    check_output("basic_symbol", decoded_symbol, exp_sym(5));
    apply_stimulus(16'sd0, 1'b1);
    check_output("basic_valid_drop", symbol_valid, 0);
    check_output("basic_symbol_hold", decoded_symbol, exp_sym(5));

    // Sample equal to threshold counts as low; one above counts as high.
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(16'sd30, 1'b1);
      check_output("equal_no_strobe", symbol_valid, 0);
    end
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(16'sd31, 1'b1);
      check_output("above_mid_valid", symbol_valid, 0);
    end
    apply_stimulus(16'sd30, 1'b1);
    check_output("boundary_valid", symbol_valid, 1);
    check_output("boundary_symbol", decoded_symbol, exp_sym(3));
    apply_stimulus(16'sd0, 1'b1);

    // Glitch rejection after a width-5 symbol.
    run_pulse(5, "glitch_pre_mid");
    apply_stimulus(16'sd0, 1'b1);
    check_output("glitch_pre_symbol", decoded_symbol, exp_sym(5));
    apply_stimulus(16'sd100, 1'b1);
    apply_stimulus(16'sd0, 1'b1);
    check_output("glitch_valid", symbol_valid, 0);
    check_output("glitch_symbol_hold", decoded_symbol, exp_sym(5));

    // Minimum accepted width.
    run_pulse(2, "min_mid_valid");
    apply_stimulus(16'sd0, 1'b1);
    check_output("min_valid", symbol_valid, 1);
    check_output("min_symbol", decoded_symbol, exp_sym(2));

    // Six high samples, enable low on two of them.
    apply_stimulus(16'sd100, 1'b1);
    apply_stimulus(16'sd100, 1'b0);
    apply_stimulus(16'sd100, 1'b1);
    apply_stimulus(16'sd100, 1'b0);
    apply_stimulus(16'sd100, 1'b1);
    apply_stimulus(16'sd100, 1'b1);
    apply_stimulus(16'sd0, 1'b1);
    check_output("enable_valid", symbol_valid, 1);
    check_output("enable_symbol", decoded_symbol, exp_sym(4));

    // Back-to-back pulses separated by a single low sample.
    run_pulse(3, "b2b_a_mid");
    apply_stimulus(16'sd0, 1'b1);
    check_output("b2b_a_symbol", decoded_symbol, exp_sym(3));
    run_pulse(4, "b2b_b_mid");
    apply_stimulus(16'sd0, 1'b1);
    check_output("b2b_b_valid", symbol_valid, 1);
    check_output("b2b_b_symbol", decoded_symbol, exp_sym(4));

    // Long pulse saturates the counter.
    run_pulse(200, "sat_mid_valid");
    apply_stimulus(16'sd0, 1'b1);
    check_output("sat_valid", symbol_valid, 1);
    check_output("sat_symbol", decoded_symbol, exp_sym(127));

    // Reset in the middle of a pulse discards the partial count.
    run_pulse(3, "rst_pre_mid");
    reset_n = 1'b0;
    apply_stimulus(16'sd100, 1'b1);
    check_output("midreset_valid", symbol_valid, 0);
    check_output("midreset_symbol", decoded_symbol, 0);
    reset_n = 1'b1;
    run_pulse(2, "rst_post_mid");
    apply_stimulus(16'sd0, 1'b1);
    check_output("midreset_after_valid", symbol_valid, 1);
    check_output("midreset_after_symbol", decoded_symbol, exp_sym(2));

    // Ten-sample pulse: -54 in the signed build, 10 otherwise.
    run_pulse(10, "ten_mid_valid");
    apply_stimulus(16'sd0, 1'b1);
    check_output("ten_valid", symbol_valid, 1);
    check_output("ten_symbol", decoded_symbol, exp_sym(10));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_symbol_decoder.md
Name: pwm_symbol_decoder

Overview:
- Pulse-width demodulator for the pwm4sdr receive path. It sits after the UHD sample stream and before the symbol consumer.
- Each clock it compares a signed baseband sample (data_in) against a signed threshold (ref_in). It measures how many enabled clocks the sample stays above threshold.
- On each pulse end it emits that width as an 8-bit signed symbol with a one-cycle valid strobe.

Parameters:
- DATA_W, 16, width of ref_in/data_in (signed).
- SYM_W, 8, width of decoded_symbol (signed).
- HYST, 0, hysteresis around ref_in, in sample LSBs (non-negative).
- MIN_PULSE, 2, minimum counted width accepted as a symbol; shorter pulses are discarded as glitches.
- CENTER_VAL, 64, offset subtracted when DECODER_SIGNED_SYMBOL_EN is defined.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- enable_counter  in  1  count enable; when low, the width counter holds.
- ref_in  in  DATA_W  signed threshold, sampled every cycle.
- data_in  in  DATA_W  signed sample, one per clock.
- decoded_symbol  out  SYM_W  signed last decoded width; holds between symbols.
- symbol_valid  out  1  one-cycle strobe, high in the cycle decoded_symbol updates.

Behaviour:
- Interface: one clock (clock); reset (reset_n) is synchronous and active-low.
- Reset (reset_n=0 at a rising edge): level_q=0, cnt=0, decoded_symbol=0, symbol_valid=0. Reset mid-pulse discards the partial pulse.
- Comparator: evaluated at DATA_W+2 bits with sign extension, so ref_in±HYST never overflows.
  - level_next=1 if data_in > ref_in+HYST.
  - level_next=0 if data_in <= ref_in−HYST.
  - Otherwise level_next=level_q.
  - With HYST=0: high iff data_in > ref_in. data_in==ref_in counts as low.
- Counter, every edge with reset_n=1:
  - level_next=1 and enable_counter=1: cnt <= min(cnt+1, 2^(SYM_W−1)−1), saturating at 127.
  - level_next=1 and enable_counter=0: cnt holds.
- Falling edge (level_q=1, level_next=0):
  - If cnt >= MIN_PULSE: decoded_symbol <= cnt and symbol_valid <= 1.
  - Else: no strobe, decoded_symbol holds.
  - cnt <= 0 in both cases.
- Latency: a pulse of N consecutive high samples with enable=1 gives symbol N. It is registered on the edge that samples the first low data_in, so it is visible one clock after that sample is presented.
- symbol_valid is 0 on every other cycle; the block never asserts it in two consecutive cycles.
- Back-to-back pulses (one low sample between): each is decoded independently.
- ref_in changing mid-pulse: the new threshold applies immediately; there is no re-sampling of past data.
- Saturated pulses report 127; decoded_symbol is always >= 0 in the default build.
- level_q=1 when reset releases is impossible (reset clears it). A pulse already high at release starts counting from 1.

Optional Feature:
- Macro DECODER_SIGNED_SYMBOL_EN.
- Defined: decoded_symbol <= sat_signed(cnt − CENTER_VAL), clamped to [−128,127]. A width of 64 yields 0, width 10 yields −54. The glitch/MIN_PULSE check still uses the raw cnt.
- Undefined: decoded_symbol is the raw saturated count, as above.

Decomposition:
- Package decoder_pkg holds:
  - DATA_W/SYM_W defaults.
  - Constant SYM_MAX = 2^(SYM_W−1)−1.
  - Function for signed saturation.
- One sub-module, pwm_level_detector: the hysteresis comparator, producing level_next and registered level_q.
- Counter, emit logic and output registers stay in the top.

Test Plan:
- Reset: reset_n=0 for 3 clocks with data_in=100, ref_in=30 -> decoded_symbol=0, symbol_valid=0 throughout.
- Basic pulse: ref_in=30, enable=1, data_in=100 for 5 clocks then 0 -> decoded_symbol=5, symbol_valid high exactly one cycle, then symbol holds 5.
- Threshold boundary: data_in=30 for 4 clocks -> no strobe. Then data_in=31 for 3 clocks then 30 -> decoded_symbol=3.
- Glitch reject: after a symbol of 5, data_in=100 for 1 clock then 0 -> no strobe, decoded_symbol stays 5.
- Enable gating and saturation:
  - 6 high clocks with enable_counter=0 on 2 of them -> decoded_symbol=4.
  - 200 high clocks -> decoded_symbol=127.
- Reset mid-pulse and signed build:
  - reset_n pulsed low after 3 high clocks, then 2 more high clocks, then low -> decoded_symbol=2.
  - With DECODER_SIGNED_SYMBOL_EN, 10-clock pulse -> decoded_symbol=−54.
